adc_lvds_frame_tx: RTL and testbench
====================================

// Module: adc_lvds_frame_tx
// PURPOSE
//  Transmit-side counterpart of the LTC2195 receive path. Serializes two 16-bit channels into the
//  ADC's 2-lane-per-channel output format, with matching DCO bit clock and FR frame clock, so
//  receiver firmware runs in loopback on the board without a live ADC. Emits single-ended
//  logic; OBUFDS pairs belong to the top level. Sample rate = clk_in / (8*CYC_PER_BIT).
// PARAMETERS
//  SAMPLE_W     16  bits per channel sample; fixed at 16, split across 2 lanes x 8 bits
//  CYC_PER_BIT  2   clk_in cycles per serial bit; even, >=2
//  REPEAT_LAST  1   1: resend last sample on underrun; 0: send 16'h0000
// PORTS
//  clk_in        in   1   single clock, drives all logic
//  rst_in        in   1   asynchronous, active-high reset
//  en_in         in   1   1: stream frames; 0: stop at the next frame boundary
//  ch0_in        in   16  channel 0 sample
//  ch1_in        in   16  channel 1 sample
//  valid_in      in   1   ch0_in/ch1_in valid
//  ready_out     out  1   holding register can accept; transfer on valid_in & ready_out
//  dco_out       out  1   bit clock; high during the 2nd half of each bit period
//  fr_out        out  1   frame clock; high for bits 0-3 of the frame, low for bits 4-7
//  d0_out        out  2   channel 0 lanes: [1]=bits 15,13..1; [0]=bits 14,12..0; MSB first
//  d1_out        out  2   channel 1 lanes, same mapping
//  underrun_out  out  1   1-cycle pulse: frame started with holding register empty
//  busy_out      out  1   1 while in RUN
// BEHAVIOUR
//  Reset: all outputs 0 except ready_out (0 during reset, 1 on the first edge after release).
//    Clears state to IDLE, holding register and last-sample register to 0.
//  Holding register: one entry.
//    ready_out = ~hold_full | frame_load.
//    Accept and drain in the same cycle is legal and leaves hold_full set.
//  State IDLE: d*/fr/dco outputs driven 0.
//    Exit to RUN when en_in & hold_full.
//    The RUN-entry edge loads the shift registers from the holding register.
//    With empty holding and valid_in & en_in at edge t: accept at t, first frame bits on outputs after edge t+1.
//  State RUN: counters phase (0..CYC_PER_BIT-1) and bitc (0..7).
//    Data updates only at phase 0; dco_out = (phase >= CYC_PER_BIT/2); fr_out = (bitc < 4).
//  Frame boundary (bitc=7 and last phase):
//    en_in=0 -> IDLE; holding register keeps its contents.
//    hold_full -> load the holding register, store it as last sample.
//    empty -> load last sample (REPEAT_LAST=1) or 0, and pulse underrun_out the next cycle.
//  en_in falling mid-frame: the current frame always completes; there are no partial frames.
//  Async reset mid-frame: outputs go 0 immediately, no clock edge required.
//  Counters wrap modulo; no overflow states. Lane shift registers are 8 bits, shifted left by 1 per bit.
// STRUCTURE
//  adc_serdes_defs.vh (shared with LTC2195 receiver):
//    SAMPLE_W, LANES=2, BITS_PER_LANE=8, state encodings ST_IDLE/ST_RUN.
//  Sub-module lane_pair_serializer: one per channel (x2).
//    Parallel load of 16 bits into odd/even 8-bit shift registers; shift on bit strobe; drives 2 lanes.
//  Top of this block: FSM, phase/bit counters, holding/last-sample registers, handshake, DCO/FR generation.
// TESTING
//  1 Reset, en=1, valid ch0=16'hA5C3 ch1=0 ->
//    d0[1] = 1,1,0,0,1,0,0,1 and d0[0] = 0,0,1,1,1,0,0,1, each bit 2 cycles.
//    fr 1 for 8 cycles then 0 for 8; dco toggles every cycle; d1=0.
//  2 valid held high with incrementing samples 1,2,3... ->
//    one accept per 16 cycles, frames carry 1,2,3 back-to-back, underrun never pulses.
//  3 One sample 16'h8001, then valid low ->
//    2nd frame repeats 16'h8001, underrun_out high for exactly 1 cycle at frame start.
//  4 en_in dropped at bitc=3 -> frame completes; outputs 0 and busy_out=0 from the 17th cycle on.
//  5 rst_in pulsed at bitc=5 phase=1, no clock edge during it -> all outputs 0 at once.
//    After release: ready_out=1 and state IDLE.
//  6 Holding full, valid_in high on the boundary cycle ->
//    ready_out=1, new sample accepted, no idle gap.
//  Loopback: this block into LTC2195 receiver -> ADC0_out/ADC1_out equal the sent samples for 1000 random frames.

Source files
------------

// File: rtl/adc_lvds_frame_tx_pkg.sv
// rtl/adc_lvds_frame_tx_pkg.sv - shared framing constants and lane split helper
// Common to the LTC2195 receive path and this loopback transmitter.
package adc_lvds_frame_tx_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int LANES         = 2;
  localparam int BITS_PER_LANE = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Odd lane carries bits 15,13..1 and even lane 14,12..0; index 7 leaves the wire first.
  function automatic logic [BITS_PER_LANE-1:0] lane_bits(input logic [SAMPLE_W-1:0] s,
                                                         input logic odd);
    logic [BITS_PER_LANE-1:0] r;
    for (int k = 0; k < BITS_PER_LANE; k++) begin
      r[k] = odd ? s[2*k+1] : s[2*k];
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_lvds_frame_tx_lane_pair_serializer.sv
// rtl/adc_lvds_frame_tx_lane_pair_serializer.sv - one channel, two 8-bit lanes
// Parallel load of a 16-bit sample into odd/even shift registers, MSB first.
module adc_lvds_frame_tx_lane_pair_serializer
  import adc_lvds_frame_tx_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                shift_i,
  input  logic [SAMPLE_W-1:0] data_i,
  output logic [LANES-1:0]    lanes_o
);

  logic [BITS_PER_LANE-1:0] odd_q, odd_d;
  logic [BITS_PER_LANE-1:0] even_q, even_d;

  always_comb begin
    odd_d  = odd_q;
    even_d = even_q;
    if (load_i) begin
      odd_d  = lane_bits(data_i, 1'b1);
      even_d = lane_bits(data_i, 1'b0);
    end else if (shift_i) begin
      odd_d  = {odd_q[BITS_PER_LANE-2:0], 1'b0};
      even_d = {even_q[BITS_PER_LANE-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      odd_q  <= '0;
      even_q <= '0;
    end else begin
      odd_q  <= odd_d;
      even_q <= even_d;
    end
  end

  assign lanes_o = {odd_q[BITS_PER_LANE-1], even_q[BITS_PER_LANE-1]};

endmodule

// File: rtl/adc_lvds_frame_tx.sv
// rtl/adc_lvds_frame_tx.sv - LTC2195-format 2-lane frame transmitter for receiver loopback
// Frame FSM, bit/phase counters, one-entry holding register, DCO and FR generation.
module adc_lvds_frame_tx #(
  parameter int SAMPLE_W    = 16,
  parameter int CYC_PER_BIT = 2,
  parameter int REPEAT_LAST = 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                en_in,
  input  logic [SAMPLE_W-1:0] ch0_in,
  input  logic [SAMPLE_W-1:0] ch1_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic                dco_out,
  output logic                fr_out,
  output logic [1:0]          d0_out,
  output logic [1:0]          d1_out,
  output logic                underrun_out,
  output logic                busy_out
);

  import adc_lvds_frame_tx_pkg::*;

  localparam int              PH_W     = (CYC_PER_BIT > 1) ? $clog2(CYC_PER_BIT) : 1;
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CYC_PER_BIT - 1);
  localparam logic [PH_W-1:0] PH_HALF  = PH_W'(CYC_PER_BIT / 2);
  localparam logic [2:0]      BIT_LAST = 3'd7;

  state_e              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [2:0]          bitc_q, bitc_d;
  logic                hold_full_q, hold_full_d;
  logic [SAMPLE_W-1:0] hold0_q, hold0_d, hold1_q, hold1_d;
  logic [SAMPLE_W-1:0] last0_q, last0_d, last1_q, last1_d;
  logic                underrun_q, underrun_d;
  logic                rdy_en_q;

  logic                frame_load;
  logic                sr_load;
  logic                sr_shift;
  logic                accept;
  logic [SAMPLE_W-1:0] load0, load1;
  logic [1:0]          lanes0, lanes1;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bitc_d     = bitc_q;
    frame_load = 1'b0;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    underrun_d = 1'b0;
    load0      = hold0_q;
    load1      = hold1_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        bitc_d  = '0;
        if (en_in && hold_full_q) begin
          state_d    = ST_RUN;
          frame_load = 1'b1;
          sr_load    = 1'b1;
        end
      end
      ST_RUN: begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        if (phase_q == PH_LAST) begin
          bitc_d = bitc_q + 1'b1;
          if (bitc_q != BIT_LAST) begin
            sr_shift = 1'b1;
          end else if (!en_in) begin
            state_d = ST_IDLE;
          end else if (hold_full_q) begin
            frame_load = 1'b1;
            sr_load    = 1'b1;
          end else begin
            // Underrun: keep the frame cadence with the last (or zero) sample.
            sr_load    = 1'b1;
            underrun_d = 1'b1;
            load0      = (REPEAT_LAST != 0) ? last0_q : '0;
            load1      = (REPEAT_LAST != 0) ? last1_q : '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rdy_en_q keeps ready low through reset and raises it on the first edge after release.
  assign ready_out = rdy_en_q & (~hold_full_q | frame_load);
  assign accept    = valid_in & ready_out;

  always_comb begin
    hold_full_d = hold_full_q;
    hold0_d     = hold0_q;
    hold1_d     = hold1_q;
    last0_d     = last0_q;
    last1_d     = last1_q;
    if (accept) begin
      hold_full_d = 1'b1;
      hold0_d     = ch0_in;
      hold1_d     = ch1_in;
    end else if (frame_load) begin
      hold_full_d = 1'b0;
    end
    if (frame_load) begin
      last0_d = hold0_q;
      last1_d = hold1_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      bitc_q      <= '0;
      hold_full_q <= 1'b0;
      hold0_q     <= '0;
      hold1_q     <= '0;
      last0_q     <= '0;
      last1_q     <= '0;
      underrun_q  <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bitc_q      <= bitc_d;
      hold_full_q <= hold_full_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
      underrun_q  <= underrun_d;
      rdy_en_q    <= 1'b1;
    end
  end

  adc_lvds_frame_tx_lane_pair_serializer u_ser0 (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (load0),
    .lanes_o (lanes0)
  );

  adc_lvds_frame_tx_lane_pair_serializer u_ser1 (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (load1),
    .lanes_o (lanes1)
  );

  // Outputs are decoded straight from registers so async reset clears them without an edge.
  assign busy_out     = (state_q == ST_RUN);
  assign dco_out      = busy_out & (phase_q >= PH_HALF);
  assign fr_out       = busy_out & (bitc_q < 3'd4);
  assign d0_out       = busy_out ? lanes0 : 2'b00;
  assign d1_out       = busy_out ? lanes1 : 2'b00;
  assign underrun_out = underrun_q;

endmodule

// File: tb/tb_adc_lvds_frame_tx.sv
// tb/tb_adc_lvds_frame_tx.sv - self-checking bench for adc_lvds_frame_tx
module tb_adc_lvds_frame_tx;

  localparam int CPB  = 2;
  localparam int FCYC = 8 * CPB;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        en_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [15:0] ch0_in = '0;
  logic [15:0] ch1_in = '0;
  logic        ready_out, dco_out, fr_out, underrun_out, busy_out;
  logic [1:0]  d0_out, d1_out;

  int n_checks = 0;
  int n_pass = 0;

  logic [15:0] src0[64];
  logic [15:0] src1[64];
  int nsrc = 0;
  int nxt = 0;

  adc_lvds_frame_tx #(.SAMPLE_W(16), .CYC_PER_BIT(CPB), .REPEAT_LAST(1)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .en_in        (en_in),
    .ch0_in       (ch0_in),
    .ch1_in       (ch1_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .dco_out      (dco_out),
    .fr_out       (fr_out),
    .d0_out       (d0_out),
    .d1_out       (d1_out),
    .underrun_out (underrun_out),
    .busy_out     (busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference waveform of one frame: bit k occupies CPB cycles, odd lane = s[15-2k], even lane = s[14-2k].
  function automatic logic [31:0] exp_lanes(input logic [15:0] s);
    logic [31:0] r;
    for (int c = 0; c < FCYC; c++) begin
      int k;
      k = c / CPB;
      r[2*c+1] = s[15-2*k];
      r[2*c]   = s[14-2*k];
    end
    return r;
  endfunction

  function automatic logic [111:0] exp_frame(input logic [15:0] s0, input logic [15:0] s1,
                                             input bit ur);
    logic [15:0] fr, dco;
    for (int c = 0; c < FCYC; c++) begin
      fr[c]  = ((c / CPB) < 4);
      dco[c] = ((c % CPB) >= (CPB / 2));
    end
    return {exp_lanes(s0), exp_lanes(s1), fr, dco, (ur ? 16'h0001 : 16'h0000), 16'hFFFF};
  endfunction

  task automatic step(input bit v);
    logic acc;
    valid_in = v && (nxt < nsrc);
    ch0_in   = src0[nxt];
    ch1_in   = src1[nxt];
    acc      = valid_in & ready_out;
    @(negedge clk_in);
    if (acc) nxt++;
    valid_in = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] vmask, input int drop_cyc,
                           output logic [111:0] got, output logic [15:0] rdyv);
    logic [31:0] d0v, d1v;
    logic [15:0] frv, dcov, urv, bsyv;
    for (int c = 0; c < FCYC; c++) begin
      if (c == drop_cyc) en_in = 1'b0;
      d0v[2*c+:2] = d0_out;
      d1v[2*c+:2] = d1_out;
      frv[c]      = fr_out;
      dcov[c]     = dco_out;
      urv[c]      = underrun_out;
      bsyv[c]     = busy_out;
      rdyv[c]     = ready_out;
      step(vmask[c]);
    end
    got = {d0v, d1v, frv, dcov, urv, bsyv};
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    n_checks++;
    if ({d0_out, d1_out, fr_out, dco_out, underrun_out, busy_out, ready_out} !== 9'b0)
      $display("FAIL reset_outputs: got %b expected 0",
               {d0_out, d1_out, fr_out, dco_out, underrun_out, busy_out, ready_out});
    else n_pass++;
    rst_in = 1'b0;
    #1;
    n_checks++;
    if (ready_out !== 1'b0) $display("FAIL reset_ready_before_edge: got %b expected 0", ready_out);
    else n_pass++;
    @(negedge clk_in);
    n_checks++;
    if ({ready_out, busy_out, d0_out} !== 4'b1000)
      $display("FAIL reset_after_edge: got %b expected 1000", {ready_out, busy_out, d0_out});
    else n_pass++;
  endtask

  task automatic test_single_frame();
    logic [111:0] got;
    logic [15:0]  rdyv;
    src0[0] = 16'hA5C3; src1[0] = 16'h0000; nsrc = 1; nxt = 0;
    en_in = 1'b1;
    step(1'b1);
    n_checks++;
    if ({busy_out, d0_out, fr_out} !== 4'b0)
      $display("FAIL first_frame_latency: got %b expected 0000", {busy_out, d0_out, fr_out});
    else n_pass++;
    step(1'b0);
    run_frame(16'h0000, 3 * CPB, got, rdyv);
    n_checks++;
    if (got !== exp_frame(16'hA5C3, 16'h0000, 1'b0))
      $display("FAIL frame_a5c3: got %h expected %h", got, exp_frame(16'hA5C3, 16'h0000, 1'b0));
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({busy_out, d0_out, d1_out, fr_out, dco_out, ready_out} !== 8'b0000_0001)
        $display("FAIL stop_after_frame[%0d]: got %b expected 00000001", i,
                 {busy_out, d0_out, d1_out, fr_out, dco_out, ready_out});
      else n_pass++;
      step(1'b0);
    end
  endtask

  task automatic test_underrun();
    logic [111:0] got;
    logic [15:0]  rdyv;
    logic [15:0]  c1;
    c1 = 16'($urandom);
    src0[0] = 16'h8001; src1[0] = c1; nsrc = 1; nxt = 0;
    en_in = 1'b1;
    step(1'b1);
    step(1'b0);
    run_frame(16'h0000, -1, got, rdyv);
    n_checks++;
    if (got !== exp_frame(16'h8001, c1, 1'b0))
      $display("FAIL underrun_frame1: got %h expected %h", got, exp_frame(16'h8001, c1, 1'b0));
    else n_pass++;
    run_frame(16'h0000, 5 * CPB, got, rdyv);
    n_checks++;
    if (got !== exp_frame(16'h8001, c1, 1'b1))
      $display("FAIL underrun_frame2: got %h expected %h", got, exp_frame(16'h8001, c1, 1'b1));
    else n_pass++;
    n_checks++;
    if (underrun_out !== 1'b0) $display("FAIL underrun_after_stop: got %b expected 0", underrun_out);
    else n_pass++;
    step(1'b0);
  endtask

  task automatic test_back_to_back();
    logic [111:0] got;
    logic [15:0]  rdyv;
    for (int i = 0; i < 6; i++) begin
      src0[i] = 16'(i + 1);
      src1[i] = 16'($urandom);
    end
    nsrc = 6; nxt = 0;
    en_in = 1'b1;
    step(1'b1);
    step(1'b1);
    for (int k = 0; k < 5; k++) begin
      run_frame((k < 4) ? 16'hFFFF : 16'h0000, (k < 4) ? -1 : 3, got, rdyv);
      n_checks++;
      if (got !== exp_frame(src0[k], src1[k], 1'b0))
        $display("FAIL b2b_frame[%0d]: got %h expected %h", k, got, exp_frame(src0[k], src1[k], 1'b0));
      else n_pass++;
      n_checks++;
      if (rdyv !== ((k < 4) ? 16'h8000 : 16'h0000))
        $display("FAIL b2b_ready[%0d]: got %h expected %h", k, rdyv, (k < 4) ? 16'h8000 : 16'h0000);
      else n_pass++;
    end
    repeat (3) step(1'b0);
    n_checks++;
    if ({busy_out, ready_out} !== 2'b00)
      $display("FAIL b2b_idle_held: got %b expected 00", {busy_out, ready_out});
    else n_pass++;
    en_in = 1'b1;
    step(1'b0);
    run_frame(16'h0000, 2, got, rdyv);
    n_checks++;
    if (got !== exp_frame(src0[5], src1[5], 1'b0))
      $display("FAIL b2b_resume_held: got %h expected %h", got, exp_frame(src0[5], src1[5], 1'b0));
    else n_pass++;
    n_checks++;
    if (nxt !== 6) $display("FAIL b2b_accept_count: got %0d expected 6", nxt);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [111:0] got;
    logic [15:0]  rdyv, vmask, exp_rdy, cur0, cur1;
    bit           ur, offer;
    int           oc, mi;
    for (int i = 0; i < 40; i++) begin
      src0[i] = 16'($urandom);
      src1[i] = 16'($urandom);
    end
    nsrc = 40; nxt = 0;
    en_in = 1'b1;
    step(1'b1);
    step(1'b0);
    cur0 = src0[0]; cur1 = src1[0]; ur = 1'b0; mi = 1;
    for (int f = 0; f < 20; f++) begin
      offer = (f < 19) && ($urandom_range(0, 1) == 1);
      oc    = $urandom_range(0, 14);
      vmask = offer ? (16'd1 << oc) : 16'd0;
      exp_rdy = offer ? (((16'd1 << (oc + 1)) - 16'd1) | 16'h8000) : 16'hFFFF;
      run_frame(vmask, (f == 19) ? 5 : -1, got, rdyv);
      n_checks++;
      if (got !== exp_frame(cur0, cur1, ur))
        $display("FAIL rand_frame[%0d]: got %h expected %h", f, got, exp_frame(cur0, cur1, ur));
      else n_pass++;
      n_checks++;
      if (rdyv !== exp_rdy) $display("FAIL rand_ready[%0d]: got %h expected %h", f, rdyv, exp_rdy);
      else n_pass++;
      if (offer) begin
        cur0 = src0[mi]; cur1 = src1[mi]; mi++; ur = 1'b0;
      end else begin
        ur = 1'b1;
      end
    end
    n_checks++;
    if (busy_out !== 1'b0) $display("FAIL rand_stopped: got %b expected 0", busy_out);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    src0[0] = 16'($urandom); src1[0] = 16'($urandom); nsrc = 1; nxt = 0;
    en_in = 1'b1;
    step(1'b1);
    step(1'b0);
    repeat (5 * CPB + 1) step(1'b0);
    n_checks++;
    if ({busy_out, dco_out, fr_out} !== 3'b110)
      $display("FAIL async_pre_state: got %b expected 110", {busy_out, dco_out, fr_out});
    else n_pass++;
    #1 rst_in = 1'b1;
    #1;
    n_checks++;
    if ({d0_out, d1_out, fr_out, dco_out, underrun_out, busy_out, ready_out} !== 9'b0)
      $display("FAIL async_reset_outputs: got %b expected 0",
               {d0_out, d1_out, fr_out, dco_out, underrun_out, busy_out, ready_out});
    else n_pass++;
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    n_checks++;
    if ({ready_out, busy_out} !== 2'b10)
      $display("FAIL async_after_release: got %b expected 10", {ready_out, busy_out});
    else n_pass++;
    repeat (3) step(1'b0);
    n_checks++;
    if ({busy_out, d0_out, fr_out} !== 4'b0)
      $display("FAIL async_stays_idle: got %b expected 0000", {busy_out, d0_out, fr_out});
    else n_pass++;
    en_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_underrun();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
